// File: rtl/cache_assoc.sv
// N-way set-associative, write-back, write-allocate cache with true-LRU replacement.
// Sits between the 32-bit processor word port and a 128-bit block memory.
module cache_assoc #(
    parameter int unsigned NUM_SETS = 4,
    parameter int unsigned NUM_WAYS = 2
) (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    output logic [31:0]  proc_rdata,
    input  logic [31:0]  proc_wdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    input  logic [127:0] mem_rdata,
    output logic [127:0] mem_wdata,
    input  logic         mem_ready
);
    localparam int unsigned IDX_W  = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 0;
    localparam int unsigned IDX_WS = (IDX_W > 0) ? IDX_W : 1;
    localparam int unsigned TAG_W  = 28 - IDX_W;
    localparam int unsigned WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    // Arrays span the full range of their index width; entries beyond NUM_SETS/NUM_WAYS idle.
    localparam int unsigned SET_N  = 1 << IDX_WS;
    localparam int unsigned WAY_N  = 1 << WAY_W;

    typedef enum logic [1:0] {StIdle, StWback, StAlloc} state_e;

    state_e             state_q, state_d;
    logic [WAY_W-1:0]   victim_q, victim_d;

    logic               valid_q [SET_N][WAY_N];
    logic               dirty_q [SET_N][WAY_N];
    logic [WAY_W-1:0]   age_q   [SET_N][WAY_N];
    logic [TAG_W-1:0]   tag_q   [SET_N][WAY_N];
    logic [127:0]       data_q  [SET_N][WAY_N];

    logic [IDX_WS-1:0]  idx;
    logic [TAG_W-1:0]   ptag;
    logic [6:0]         word_off;
    logic               req;
    logic               hit;
    logic [WAY_W-1:0]   hit_way;
    logic [WAY_W-1:0]   vict;
    logic               found;

    if (IDX_W == 0) begin : g_one_set
        assign idx = '0;
    end else begin : g_sets
        assign idx = proc_addr[2 +: IDX_W];
    end

    assign ptag     = proc_addr[29 -: TAG_W];
    assign word_off = {proc_addr[1:0], 5'd0};
    assign req      = proc_read | proc_write;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[idx][w] && (tag_q[idx][w] == ptag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Lowest-index invalid way wins; otherwise the oldest way.
    always_comb begin
        vict  = '0;
        found = 1'b0;
        for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) begin
                vict  = WAY_W'(w);
                found = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (age_q[idx][w] == WAY_W'(NUM_WAYS - 1)) vict = WAY_W'(w);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        victim_d   = victim_q;
        proc_stall = 1'b0;
        proc_rdata = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_q)
            StIdle: begin
                if (req && !hit) begin
                    proc_stall = 1'b1;
                    victim_d   = vict;
                    state_d    = dirty_q[idx][vict] ? StWback : StAlloc;
                end else if (proc_read && hit) begin
                    proc_rdata = data_q[idx][hit_way][word_off +: 32];
                end
            end
            StWback: begin
                proc_stall = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = (28'(tag_q[idx][victim_q]) << IDX_W) | 28'(idx);
                mem_wdata  = data_q[idx][victim_q];
                if (mem_ready) state_d = StAlloc;
            end
            StAlloc: begin
                proc_stall = 1'b1;
                mem_read   = 1'b1;
                mem_addr   = proc_addr[29:2];
                if (mem_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge proc_reset) begin
        if (!proc_reset) begin
            state_q  <= StIdle;
            victim_q <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= WAY_W'(w);
                end
            end
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            case (state_q)
                StIdle: begin
                    if (req && hit) begin
                        if (proc_write) dirty_q[idx][hit_way] <= 1'b1;
                        for (int w = 0; w < NUM_WAYS; w++) begin
                            if (WAY_W'(w) == hit_way) begin
                                age_q[idx][w] <= '0;
                            end else if (age_q[idx][w] < age_q[idx][hit_way]) begin
                                age_q[idx][w] <= age_q[idx][w] + 1'b1;
                            end
                        end
                    end
                end
                StWback: begin
                    if (mem_ready) dirty_q[idx][victim_q] <= 1'b0;
                end
                StAlloc: begin
                    if (mem_ready) begin
                        valid_q[idx][victim_q] <= 1'b1;
                        dirty_q[idx][victim_q] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data storage carry no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (state_q == StIdle && req && hit && proc_write) begin
            data_q[idx][hit_way][word_off +: 32] <= proc_wdata;
        end
        if (state_q == StAlloc && mem_ready) begin
            tag_q[idx][victim_q]  <= ptag;
            data_q[idx][victim_q] <= mem_rdata;
        end
    end

endmodule
